mem_stage: RTL

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 138 +++++++++++++
 1 files changed

// File: rtl/mem_stage.sv
`default_nettype none
//------------------------------------------------------------------------------
//  Module   : mem_stage
//  Brief    : Memory-access pipeline stage. Registers the EX->MEM bus, extracts
//             and extends load data from the data SRAM, and drives the MEM->WB
//             pipeline bus plus the MEM->ID forwarding bus.
//  Revision : 1.0  initial release
//------------------------------------------------------------------------------
module mem_stage (
    input  logic         clk,
    input  logic         rst,
    input  logic [5:0]   stall,
    input  logic [138:0] ex_to_mem_bus,
    input  logic [31:0]  data_sram_rdata,
    output logic [135:0] mem_to_wb_bus,
    output logic [103:0] mem_to_id_bus
);

    // Load-type encodings carried in the EX->MEM bus
    localparam logic [2:0] LT_LB  = 3'b001;
    localparam logic [2:0] LT_LBU = 3'b010;
    localparam logic [2:0] LT_LH  = 3'b011;
    localparam logic [2:0] LT_LHU = 3'b100;
    localparam logic [2:0] LT_LW  = 3'b101;

    // Stall decode: only the MEM and WB stall bits matter to this stage
    logic stall_mem;
    logic stall_wb;
    logic bubble;
    logic capture;

    assign stall_mem = stall[3];
    assign stall_wb  = stall[4];
    // MEM stalled while WB moves on: WB must see an empty slot
    assign bubble    = stall_mem & ~stall_wb;
    assign capture   = ~stall_mem;

    // Remaining stall bits belong to other stages
    logic unused_stall;
    assign unused_stall = ^{stall[5], stall[2:0]};

    logic [138:0] mem_r;
    logic         first_r;
    logic [31:0]  rdata_r;

    // Pipeline register: reset and bubble clear, capture when MEM runs, else hold
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_r <= '0;
        end else if (bubble) begin
            mem_r <= '0;
        end else if (capture) begin
            mem_r <= ex_to_mem_bus;
        end
    end

    // Marks the first cycle an instruction sits in MEM (SRAM data is live only then)
    always_ff @(posedge clk) begin
        if (rst) begin
            first_r <= 1'b0;
        end else begin
            first_r <= capture;
        end
    end

    // Keeps the first-cycle SRAM data so a stalled load still sees it later
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_r <= '0;
        end else if (first_r) begin
            rdata_r <= data_sram_rdata;
        end
    end

    // Field unpack of the registered EX->MEM bus
    logic        hi_we;
    logic [31:0] hi;
    logic        lo_we;
    logic [31:0] lo;
    logic [31:0] pc;
    logic [2:0]  load_type;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] ex_result;

    assign hi_we     = mem_r[138];
    assign hi        = mem_r[137:106];
    assign lo_we     = mem_r[105];
    assign lo        = mem_r[104:73];
    assign pc        = mem_r[72:41];
    assign load_type = mem_r[40:38];
    assign rf_we     = mem_r[37];
    assign rf_waddr  = mem_r[36:32];
    assign ex_result = mem_r[31:0];

    // Live SRAM data on the first cycle, the held copy afterwards
    logic [31:0] load_word;
    assign load_word = first_r ? data_sram_rdata : rdata_r;

    logic [7:0]  load_byte;
    logic [15:0] load_half;

    // Little-endian byte lane select from the low address bits
    always_comb begin
        load_byte = load_word[7:0];
        case (ex_result[1:0])
            2'b00:   load_byte = load_word[7:0];
            2'b01:   load_byte = load_word[15:8];
            2'b10:   load_byte = load_word[23:16];
            default: load_byte = load_word[31:24];
        endcase
    end

    // Halfword lane select; address bit 0 is ignored, no alignment trap
    always_comb begin
        load_half = ex_result[1] ? load_word[31:16] : load_word[15:0];
    end

    logic [31:0] rf_wdata;

    // Extend the selected lane per load type; non-loads forward the ALU result
    always_comb begin
        rf_wdata = ex_result;
        case (load_type)
            LT_LB:   rf_wdata = {{24{load_byte[7]}}, load_byte};
            LT_LBU:  rf_wdata = {24'h0, load_byte};
            LT_LH:   rf_wdata = {{16{load_half[15]}}, load_half};
            LT_LHU:  rf_wdata = {16'h0, load_half};
            LT_LW:   rf_wdata = load_word;
            default: rf_wdata = ex_result;
        endcase
    end

    assign mem_to_wb_bus = {hi_we, hi, lo_we, lo, pc, rf_we, rf_waddr, rf_wdata};
    assign mem_to_id_bus = {hi_we, hi, lo_we, lo, rf_we, rf_waddr, rf_wdata};

endmodule
`default_nettype wire
